sram_like_slave_bridge: RTL
===========================

// Module: sram_like_slave_bridge
// PURPOSE
//   Responder end of the sram-like req/addr_ok/data_ok bus driven by the IF and MEM stages.
//   It accepts read/write requests, performs each on a synchronous single-port RAM (1-cycle read latency),
//   and returns exactly one data_ok per accepted request, strictly in order.
//   Holds up to DEPTH outstanding requests, so masters see back-pressure and decoupled responses.
// PARAMETERS
//   DEPTH      4          max outstanding requests (accepted, data_ok not yet given); power of 2, >=2
//   RAM_AW     16         RAM word-index width; ram_addr = addr[RAM_AW+1:2], upper addr bits alias
//   LFSR_SEED  16'hACE1   reset value of the stall LFSR (used only with SRAM_LIKE_RAND_STALL_EN)
// PORTS
//   clk        in   1       clock, all state on posedge
//   resetn     in   1       asynchronous, active-low reset
//   req        in   1       request valid
//   wr         in   1       1=write, 0=read
//   size       in   2       0=byte,1=half,2=word (informational; byte lanes come from wstrb)
//   wstrb      in   4       write byte enables
//   addr       in   32      byte address; addr[1:0] ignored for indexing
//   wdata      in   32      write data
//   addr_ok    out  1       request accepted when req&addr_ok
//   data_ok    out  1       response valid (one per accepted request, in order)
//   rdata      out  32      read data, valid only while data_ok
//   rsp_stall  in   1       1 = suppress data_ok this cycle (hold responses)
//   ram_en     out  1       RAM access this cycle
//   ram_we     out  4       RAM byte write enables
//   ram_addr   out  RAM_AW  RAM word index
//   ram_wdata  out  32      RAM write data
//   ram_rdata  in   32      RAM read data, valid cycle after ram_en
// BEHAVIOUR
//   - Reset (async, resetn=0): addr_ok=0, data_ok=0, rdata=0, ram_en=0, ram_we=0, outstanding count=0,
//     FIFO empty, in-flight flag clear; all requests outstanding at reset are dropped with no data_ok after.
//   - cnt = registered outstanding count; addr_ok = (cnt < DEPTH); addr_ok may be 1 without req.
//     cnt updates by +(req&addr_ok) -(data_ok); no same-cycle credit: at cnt==DEPTH, addr_ok stays 0 even if data_ok fires.
//   - Handshake at cycle N: ram_en=1, ram_addr=addr[RAM_AW+1:2], ram_wdata=wdata,
//     ram_we = wr ? wstrb : 4'b0 (all combinational from inputs in cycle N). Otherwise ram_en=0, ram_we=0.
//   - Cycle N+1: result {wr, wr?32'b0:ram_rdata} available. If FIFO empty and rsp_stall=0 -> bypass:
//     data_ok=1, rdata=result (min latency 1 cycle). Else result pushed into response FIFO.
//   - FIFO nonempty and rsp_stall=0 -> data_ok=1, rdata=head, pop; new result pushed same cycle (push+pop legal).
//   - FIFO never overflows: entries <= cnt <= DEPTH. Pointers wrap modulo DEPTH.
//   - Writes also get data_ok with rdata=0. rdata=0 whenever data_ok=0.
//   - Back-to-back handshakes every cycle sustained (throughput 1/cycle) while rsp_stall=0.
// CONFIGURATION
//   SRAM_LIKE_RAND_STALL_EN defined: 16-bit Fibonacci LFSR (taps 16,14,13,11), reset to LFSR_SEED,
//     advances every cycle; addr_ok additionally gated off when lfsr[1:0]==0, data_ok
//     (incl. bypass) additionally suppressed when lfsr[3:2]==0. Stresses master retry/hold logic.
//   Not defined: no LFSR; only cnt and rsp_stall gate the handshakes.
// STRUCTURE
//   Package sram_like_pkg: SIZE_BYTE/SIZE_HALF/SIZE_WORD constants, rsp_entry_t {logic wr; logic [31:0] data}.
//   Sub-module sram_rsp_fifo (DEPTH x rsp_entry_t, push/pop/empty/head, async active-low reset).
//   Top holds cnt, in-flight flag (1-cycle delayed handshake + wr), bypass mux, optional LFSR.
// TESTING
//   1. RAM word 0x00000000 preloaded 0x12345678; read addr 0x1C000000 (RAM_AW=16) -> data_ok at N+1, rdata=0x12345678.
//   2. write addr 0x10 wstrb 4'b0010 wdata 0x0000AB00 over 0xFFFFFFFF, then read 0x10 -> rdata=0xFFFFABFF; write data_ok rdata=0.
//   3. rsp_stall=1, 4 reads to 0x0,0x4,0x8,0xC -> addr_ok=0 after 4th; release -> 4 consecutive data_ok, order kept.
//   4. at cnt=4 pulse rsp_stall=0 one cycle -> one data_ok, addr_ok=0 that cycle, 1 next cycle.
//   5. resetn=0 for 1 cycle with 2 outstanding -> data_ok=0 immediately; after release no stale data_ok, addr_ok=1.
//   6. macro on: 1000 random reads/writes vs scoreboard -> all match in order, addr_ok and data_ok each low in some cycles.

Source files
------------

// File: rtl/sram_like_slave_bridge_pkg.sv
// Shared types for the sram-like slave bridge: access-size codes and the response FIFO entry.
package sram_like_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef struct packed {
        logic        wr;
        logic [31:0] data;
    } rsp_entry_t;

endpackage

// File: rtl/sram_like_slave_bridge_if.sv
// sram-like req/addr_ok/data_ok bus between an IF/MEM-stage master and the slave bridge.
interface sram_like_slave_bridge_if;

    // A request transfers on a rising edge where req & addr_ok; the master holds req and its
    // payload until then. Each accepted request later gets exactly one single-cycle data_ok,
    // in acceptance order, with no ready path back from the master.
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );

endinterface

// File: rtl/sram_like_slave_bridge_rsp_fifo.sv
// In-order response queue (DEPTH entries) holding results that could not be returned immediately.
module sram_rsp_fifo
    import sram_like_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       push_i,
    input  rsp_entry_t push_data_i,
    input  logic       pop_i,
    output logic       empty_o,
    output rsp_entry_t head_o
);

    localparam int PW = $clog2(DEPTH);

    // One extra pointer bit tells full from empty; the bridge never pushes when full.
    logic [PW:0] wptr_q, rptr_q;
    rsp_entry_t  mem_q [DEPTH];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + 1'b1;
            if (pop_i)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wptr_q[PW-1:0]] <= push_data_i;
    end

    assign empty_o = (wptr_q == rptr_q);
    assign head_o  = mem_q[rptr_q[PW-1:0]];

endmodule

// File: rtl/sram_like_slave_bridge.sv
// sram-like bus slave in front of a 1-cycle-latency synchronous RAM, up to DEPTH outstanding.
// Optional SRAM_LIKE_RAND_STALL_EN adds LFSR-driven random stalls on addr_ok and data_ok.
module sram_like_slave_bridge
    import sram_like_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter int          RAM_AW    = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  resetn,
    sram_like_slave_bridge_if.slave bus,
    input  logic                  rsp_stall,
    output logic                  ram_en,
    output logic [3:0]            ram_we,
    output logic [RAM_AW-1:0]     ram_addr,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          inflight_q, inflight_wr_q;
    logic          accept_gate, rsp_gate;
    logic          addr_ok_w, hs, rsp_ok, data_ok_w;
    logic          fifo_empty, fifo_push, fifo_pop;
    rsp_entry_t    result, head;
    logic [31:0]   rdata_w;

`ifdef SRAM_LIKE_RAND_STALL_EN
    logic [15:0] lfsr_q;
    logic        lfsr_fb;

    // Fibonacci taps 16,14,13,11.
    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) lfsr_q <= LFSR_SEED;
        else         lfsr_q <= {lfsr_q[14:0], lfsr_fb};
    end

    assign accept_gate = (lfsr_q[1:0] != 2'b00);
    assign rsp_gate    = (lfsr_q[3:2] != 2'b00);
`else
    localparam logic [15:0] unused_lfsr_seed = LFSR_SEED;
    assign accept_gate = 1'b1;
    assign rsp_gate    = 1'b1;
`endif

    // Credit comes only from the registered count, so a data_ok never frees a slot that cycle.
    assign addr_ok_w = resetn && (cnt_q < CW'(DEPTH)) && accept_gate;
    assign hs        = bus.req & addr_ok_w;

    assign ram_en    = hs;
    assign ram_we    = (hs && bus.wr) ? bus.wstrb : 4'b0000;
    assign ram_addr  = bus.addr[RAM_AW+1:2];
    assign ram_wdata = bus.wdata;

    assign result.wr   = inflight_wr_q;
    assign result.data = inflight_wr_q ? 32'h0 : ram_rdata;

    // The fresh RAM result bypasses the queue only when nothing older is waiting.
    assign rsp_ok    = !rsp_stall && rsp_gate;
    assign fifo_pop  = rsp_ok && !fifo_empty;
    assign fifo_push = inflight_q && !(rsp_ok && fifo_empty);
    assign data_ok_w = rsp_ok && (!fifo_empty || inflight_q);

    always_comb begin
        rdata_w = 32'h0;
        if (data_ok_w) begin
            if (!fifo_empty) rdata_w = head.wr ? 32'h0 : head.data;
            else             rdata_w = result.data;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (hs)        cnt_d = cnt_d + 1'b1;
        if (data_ok_w) cnt_d = cnt_d - 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q         <= '0;
            inflight_q    <= 1'b0;
            inflight_wr_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            inflight_q    <= hs;
            inflight_wr_q <= hs & bus.wr;
        end
    end

    sram_rsp_fifo #(.DEPTH(DEPTH)) u_rsp_fifo (
        .clk         (clk),
        .resetn      (resetn),
        .push_i      (fifo_push),
        .push_data_i (result),
        .pop_i       (fifo_pop),
        .empty_o     (fifo_empty),
        .head_o      (head)
    );

    assign bus.addr_ok = addr_ok_w;
    assign bus.data_ok = data_ok_w;
    assign bus.rdata   = rdata_w;

    // Size is informational and upper/lower address bits alias; they are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{bus.size, bus.addr[31:RAM_AW+2], bus.addr[1:0]};

endmodule
